// File: rtl/lcl_mem_responder.sv
// ============================================================================
// Module   : lcl_mem_responder
// Purpose  : Responder end of the local burst interface. Independent read and
//            write burst channels are served from an internal dual-port word
//            memory. Optional macro LCL_MEM_WR_FWD_EN selects write-first
//            behaviour for a same-cycle same-word read/write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcl_mem_responder #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lcl_istart,
  input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
  input  logic [7:0]            lcl_inum,
  output logic                  lcl_ibusy,
  output logic                  lcl_irdy,
  input  logic                  lcl_den,
  input  logic [DATA_WIDTH-1:0] lcl_din,
  input  logic                  lcl_idone,
  input  logic                  lcl_ostart,
  input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
  input  logic [7:0]            lcl_onum,
  output logic                  lcl_obusy,
  output logic                  lcl_ordy,
  input  logic                  lcl_rden,
  output logic                  lcl_dv,
  output logic [DATA_WIDTH-1:0] lcl_dout,
  output logic                  lcl_odone,
  output logic                  proto_err
);

  localparam int c_offs  = $clog2(DATA_WIDTH / 8);
  localparam int c_depth = 1 << MEM_DEPTH_LOG2;
  localparam logic [MEM_DEPTH_LOG2-1:0] c_ptr_one = 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RUN  = 2'd1,
    R_LAST = 2'd2
  } rstate_t;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RUN  = 1'b1
  } wstate_t;

  rstate_t r_rstate, w_rnext;
  wstate_t r_wstate, w_wnext;

  logic [DATA_WIDTH-1:0]     r_mem [c_depth];
  logic [MEM_DEPTH_LOG2-1:0] r_rptr, r_wptr;
  logic [8:0]                r_rrem, r_wrem;
  logic                      r_dv;
  logic [DATA_WIDTH-1:0]     r_dout;
  logic                      r_perr;

  logic [MEM_DEPTH_LOG2-1:0] w_oidx, w_iidx;
  logic [8:0]                w_onum9, w_inum9;
  logic                      w_rd_en, w_wr_en, w_err;
  logic [DATA_WIDTH-1:0]     w_rd_data;
  logic                      w_unused_addr;

  // Only the word-index field of each address matters; the rest aliases.
  assign w_oidx        = lcl_oaddr[c_offs +: MEM_DEPTH_LOG2];
  assign w_iidx        = lcl_iaddr[c_offs +: MEM_DEPTH_LOG2];
  assign w_unused_addr = ^{lcl_oaddr, lcl_iaddr};

  assign w_onum9 = (lcl_onum == 8'd0) ? 9'd256 : {1'b0, lcl_onum};
  assign w_inum9 = (lcl_inum == 8'd0) ? 9'd256 : {1'b0, lcl_inum};

  assign w_rd_en = (r_rstate == R_RUN) && lcl_rden;
  assign w_wr_en = (r_wstate == W_RUN) && lcl_den && (r_wrem != 9'd0);

`ifdef LCL_MEM_WR_FWD_EN
  assign w_rd_data = (w_wr_en && (r_wptr == r_rptr)) ? lcl_din : r_mem[r_rptr];
`else
  assign w_rd_data = r_mem[r_rptr];
`endif

  assign w_err = (lcl_ostart && (r_rstate != R_IDLE)) ||
                 (lcl_istart && (r_wstate == W_RUN))  ||
                 (lcl_den && !w_wr_en)                 ||
                 (lcl_idone && (r_wstate == W_IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (lcl_ostart) w_rnext = R_RUN;
      R_RUN:   if (w_rd_en && (r_rrem == 9'd1)) w_rnext = R_LAST;
      R_LAST:  w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (lcl_istart) w_wnext = W_RUN;
      W_RUN:   if (lcl_idone) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr <= '0;
      r_rrem <= 9'd0;
      r_wptr <= '0;
      r_wrem <= 9'd0;
      r_dv   <= 1'b0;
      r_dout <= '0;
      r_perr <= 1'b0;
    end else begin
      if ((r_rstate == R_IDLE) && lcl_ostart) begin
        r_rptr <= w_oidx;
        r_rrem <= w_onum9;
      end else if (w_rd_en) begin
        r_rptr <= r_rptr + c_ptr_one;
        r_rrem <= r_rrem - 9'd1;
      end

      if ((r_wstate == W_IDLE) && lcl_istart) begin
        r_wptr <= w_iidx;
        r_wrem <= w_inum9;
      end else if (w_wr_en) begin
        r_wptr <= r_wptr + c_ptr_one;
        r_wrem <= r_wrem - 9'd1;
      end

      r_dv <= w_rd_en;
      if (w_rd_en) r_dout <= w_rd_data;
      if (w_err) r_perr <= 1'b1;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= lcl_din;
  end

  assign lcl_obusy = (r_rstate != R_IDLE);
  assign lcl_ordy  = (r_rstate == R_RUN);
  assign lcl_odone = (r_rstate == R_LAST);
  assign lcl_ibusy = (r_wstate == W_RUN);
  assign lcl_irdy  = (r_wstate == W_RUN);
  assign lcl_dv    = r_dv;
  assign lcl_dout  = r_dout;
  assign proto_err = r_perr;

endmodule

`default_nettype wire

// File: doc/lcl_mem_responder.md
# lcl_mem_responder

Responder (target) end of the local burst interface driven by the memory copy engine: accepts read bursts (`lcl_ostart`/`lcl_oaddr`/`lcl_onum`) and write bursts (`lcl_istart`/`lcl_iaddr`/`lcl_inum`) and serves them from an internal dual-port word memory. It stands in for host/DDR memory in action-level simulation and small on-chip loopback builds. The two channels run independently and concurrently, so one initiator can read and write through it at the same time.

## Interface
- `ADDR_WIDTH`, 64, byte address width of both channels.
- `DATA_WIDTH`, 512, beat width; one beat = one memory word = DATA_WIDTH/8 bytes (64 B at default).
- `MEM_DEPTH_LOG2`, 10, log2 of memory depth in words (default 1024 words = 64 KiB).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `lcl_istart`  in  1  write burst request (one-cycle pulse).
- `lcl_iaddr`  in  ADDR_WIDTH  write burst start byte address.
- `lcl_inum`  in  8  write burst beat count.
- `lcl_ibusy`  out  1  write channel busy.
- `lcl_irdy`  out  1  ready to accept write beats.
- `lcl_den`  in  1  write beat valid.
- `lcl_din`  in  DATA_WIDTH  write beat data.
- `lcl_idone`  in  1  initiator marks write burst complete (pulse).
- `lcl_ostart`  in  1  read burst request (one-cycle pulse).
- `lcl_oaddr`  in  ADDR_WIDTH  read burst start byte address.
- `lcl_onum`  in  8  read burst beat count.
- `lcl_obusy`  out  1  read channel busy.
- `lcl_ordy`  out  1  ready to serve read beats.
- `lcl_rden`  in  1  read beat request.
- `lcl_dv`  out  1  read data valid.
- `lcl_dout`  out  DATA_WIDTH  read data.
- `lcl_odone`  out  1  read burst complete (one-cycle pulse).
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- Word index = byte address bits [log2(DATA_WIDTH/8)+MEM_DEPTH_LOG2-1 : log2(DATA_WIDTH/8)]; lower bits ignored; higher bits ignored (address aliases modulo memory size). Index increments per beat and wraps from 2^MEM_DEPTH_LOG2-1 to 0.
- Beat count: `*num` = N means N beats; N = 0 means 256 beats. Beat counters are 9 bits.
- Read FSM R_IDLE -> R_RUN -> R_LAST -> R_IDLE.
  - R_IDLE: obusy=0, ordy=0. `lcl_ostart` captures address/count -> R_RUN.
  - R_RUN: obusy=1, ordy=1. Each cycle with `lcl_rden`: read mem[rptr], rptr++, rcnt++. On the rden accepting the final beat -> R_LAST.
  - R_LAST: obusy=1, ordy=0; last `lcl_dv` and `lcl_odone` asserted together this cycle -> R_IDLE.
  - `lcl_rden` outside R_RUN is ignored (not an error; initiator rden is registered and may lag ordy).
- Write FSM W_IDLE -> W_RUN -> W_IDLE.
  - W_IDLE: ibusy=0, irdy=0. `lcl_istart` captures address/count -> W_RUN.
  - W_RUN: ibusy=1, irdy=1. Each `lcl_den`: mem[wptr] <= `lcl_din`, wptr++, wcnt++. `lcl_idone` -> W_IDLE (den in same cycle is still written if within count).
- `proto_err` set (cleared only by reset) on: `lcl_istart` while ibusy or `lcl_ostart` while obusy (request ignored); `lcl_den` in W_IDLE or beyond captured count (beat dropped); `lcl_idone` in W_IDLE.
- Simultaneous read and write to the same index in one cycle: read returns old contents (read-first), unless the macro below is defined.
- Memory contents are not reset.

## Timing
- Reset values: lcl_ibusy=0, lcl_irdy=0, lcl_obusy=0, lcl_ordy=0, lcl_dv=0, lcl_dout=0, lcl_odone=0, proto_err=0; both FSMs in IDLE.
- Start to busy/ready: request at cycle t -> busy and rdy high at t+1.
- Read latency: `lcl_rden` at cycle t -> `lcl_dv`/`lcl_dout` at t+1; back-to-back rden gives one beat per cycle.
- Final rden at t: ordy low at t+1, dv+odone at t+1, obusy low at t+2; a new `lcl_ostart` is accepted from t+2.
- Write: `lcl_den` at t -> memory updated at end of t, readable by rden at t+1. `lcl_idone` at t -> ibusy/irdy low at t+1.
- Reset asserted mid-burst: both FSMs return to IDLE immediately, in-flight beats discarded, no odone.

## Configuration
- `LCL_MEM_WR_FWD_EN`: defined -> same-cycle same-index read/write forwards `lcl_din` to the read data (write-first). Undefined -> read-first, old data returned. All other behaviour identical.

## Test plan
- Write burst iaddr=0x0, inum=4, din=1..4, then idone; read burst oaddr=0x0, onum=4, rden held -> dout 1,2,3,4 on consecutive cycles, odone coincident with 4th dv, proto_err=0.
- onum=0 from oaddr=0x0 after filling 256 words -> exactly 256 dv beats, one odone, obusy low two cycles after 256th rden.
- Wrap: write 4 beats at word 1022 (byte 0xFF80) -> data lands at words 1022,1023,0,1; read at 0x0 onum=2 returns beats 3,4.
- Concurrent loopback: read 0x0 / write 0x10000 both 8 beats, den = rden delayed 1 cycle -> words 0-7 copied; read 0x10000 (aliases to 0x0) returns them.
- Same-cycle rden/den on word 5 (old 0xA, new 0xB) -> dout 0xA without macro, 0xB with `LCL_MEM_WR_FWD_EN`.
- Violations: den in W_IDLE, second istart while ibusy, 5th den on inum=4 -> proto_err=1 and stays 1; memory unchanged by the dropped beats; rst_n low mid-read -> dv/odone never assert, all outputs reset values.
